// File: rtl/div_pkg.sv
// Shared types and constants for the iterative EX-stage divider.
// Op encodings, FSM states and the divide-by-zero quotient value.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_MOD  = 2'b10,
        OP_MODU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        CALC = 2'b10,
        DONE = 2'b11
    } div_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    // Magnitude of a value, treating it as two's complement only if sgn.
    function automatic logic [31:0] mag32(
        input logic [31:0] v,
        input logic        sgn
    );
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration.
// Shifts the combined remainder/quotient register and trial-subtracts.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] rem,
    input  logic [XLEN-1:0]   divisor,
    output logic [2*XLEN-1:0] rem_next,
    output logic              q_bit
);

    logic [XLEN:0]     upper;
    logic [XLEN-1:0]   diff;
    logic [2*XLEN-1:0] shifted;

    // Upper half after the shift can need one extra bit.
    assign upper   = rem[2*XLEN-1:XLEN-1];
    assign shifted = {rem[2*XLEN-2:0], 1'b0};
    assign q_bit   = (upper >= {1'b0, divisor});
    // When the trial succeeds the difference is below the divisor,
    // so the low XLEN bits are exact.
    assign diff    = upper[XLEN-1:0] - divisor;

    // Keep the subtraction only when it did not go negative.
    always_comb begin
        rem_next = shifted;
        if (q_bit) begin
            rem_next = {diff, shifted[XLEN-1:0]};
        end
    end

endmodule

// File: rtl/fu_div.sv
// Iterative 32-bit divider for the EX stage.
// Holds the pipeline via div_stall until the registered result is ready.
module fu_div
    import div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            EX_div_en,
    input  logic [1:0]      EX_div_op,
    input  logic [XLEN-1:0] EX_div_src1,
    input  logic [XLEN-1:0] EX_div_src2,
    output logic            div_stall,
    output logic            EX_div_done,
    output logic [XLEN-1:0] EX_div_result
);

    div_state_e        state;
    div_op_e           op_q;
    logic [XLEN-1:0]   s1_q;
    logic [XLEN-1:0]   s2_q;
    logic [XLEN-1:0]   dvsr_q;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] rem_q;
    logic [5:0]        cnt_q;
    logic              q_neg;
    logic              r_neg;
    logic              done_q;

    logic              sgn_op;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [XLEN-1:0]   zero_res;
    logic [2*XLEN-1:0] step_rem;
    logic              step_q;
    logic [2*XLEN-1:0] fin;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rmd;
    logic [XLEN-1:0]   calc_res;

    assign sgn_op   = ~op_q[0];
    assign mag1     = mag32(s1_q, sgn_op);
    assign mag2     = mag32(s2_q, sgn_op);
    assign zero_res = op_q[1] ? s1_q : DIV_BY_ZERO_Q;

    div_step #(
        .XLEN     (XLEN)
    ) u_step (
        .rem      (rem_q),
        .divisor  (dvsr_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign fin = step_rem | {{(2*XLEN-1){1'b0}}, step_q};

    // Sign-correct the final step so the result is ready on DONE entry.
    always_comb begin
        quo = fin[XLEN-1:0];
        rmd = fin[2*XLEN-1:XLEN];
        if (q_neg) begin
            quo = ~quo + 1'b1;
        end
        if (r_neg) begin
            rmd = ~rmd + 1'b1;
        end
        calc_res = op_q[1] ? rmd : quo;
    end

    // Control FSM plus datapath registers; flush overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_DIV;
            s1_q     <= '0;
            s2_q     <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (EX_div_en) begin
                        s1_q  <= EX_div_src1;
                        s2_q  <= EX_div_src2;
                        op_q  <= div_op_e'(EX_div_op);
                        state <= PREP;
                    end
                end
                PREP: begin
                    rem_q  <= {{XLEN{1'b0}}, mag1};
                    dvsr_q <= mag2;
                    q_neg  <= sgn_op & (s1_q[XLEN-1] ^ s2_q[XLEN-1]);
                    r_neg  <= sgn_op & s1_q[XLEN-1];
                    cnt_q  <= '0;
                    if (s2_q == '0) begin
                        result_q <= zero_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= fin;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(ITER - 1)) begin
                        result_q <= calc_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (!stall) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign div_stall     = EX_div_en & (state != DONE) & ~flush;
    assign EX_div_done   = done_q;
    assign EX_div_result = result_q;

endmodule

// File: tb/tb_fu_div.sv
// Scoreboard bench for fu_div.
// Driver queues expected results; a monitor checks them on EX_div_done.
module tb_fu_div;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        EX_div_en;
    logic [1:0]  EX_div_op;
    logic [31:0] EX_div_src1;
    logic [31:0] EX_div_src2;
    logic        div_stall;
    logic        EX_div_done;
    logic [31:0] EX_div_result;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          start_q[$];
    int          lat_q[$];
    string       name_q[$];

    fu_div #(
        .XLEN          (32),
        .ITER          (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .EX_div_en     (EX_div_en),
        .EX_div_op     (EX_div_op),
        .EX_div_src1   (EX_div_src1),
        .EX_div_src2   (EX_div_src2),
        .div_stall     (div_stall),
        .EX_div_done   (EX_div_done),
        .EX_div_result (EX_div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on each new DONE, checks held values.
    initial begin
        logic        prev;
        logic [31:0] last;
        logic [31:0] e;
        int          s;
        int          l;
        string       n;
        prev = 1'b0;
        last = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (EX_div_done && !prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got result %h expected no done",
                                 EX_div_result);
                    end else begin
                        e = exp_q.pop_front();
                        s = start_q.pop_front();
                        l = lat_q.pop_front();
                        n = name_q.pop_front();
                        chk(n, EX_div_result, e);
                        chk({n, "_latency"}, 32'(cyc - s), 32'(l));
                        last = e;
                    end
                end else if (EX_div_done && prev) begin
                    chk("held_result", EX_div_result, last);
                end
                prev = EX_div_done;
            end
        end
    end

    task automatic run_op(input string nm, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat,
                          input int hold);
        bit got;
        @(negedge clk);
        EX_div_en   = 1'b1;
        EX_div_op   = op;
        EX_div_src1 = a;
        EX_div_src2 = b;
        exp_q.push_back(exp);
        start_q.push_back(cyc);
        lat_q.push_back(lat);
        name_q.push_back(nm);
        #1;
        chk({nm, "_stall_c0"}, 32'(div_stall), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (EX_div_done) got = 1'b1;
            else chk({nm, "_stall_busy"}, 32'(div_stall), 32'd1);
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done expected done", nm);
            exp_q.delete();
            start_q.delete();
            lat_q.delete();
            name_q.delete();
        end else begin
            chk({nm, "_stall_done"}, 32'(div_stall), 32'd0);
            if (hold > 0) begin
                stall = 1'b1;
                for (int k = 1; k <= hold; k++) begin
                    @(negedge clk);
                    chk({nm, "_hold_done"}, 32'(EX_div_done), 32'd1);
                    if (k == hold) stall = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        EX_div_en = 1'b0;
        @(negedge clk);
        chk({nm, "_no_restart"}, 32'(EX_div_done), 32'd0);
    endtask

    task automatic watch_quiet(input string nm, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (EX_div_done) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        EX_div_en   = 1'b0;
        EX_div_op   = 2'b00;
        EX_div_src1 = '0;
        EX_div_src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 32'(EX_div_done), 32'd0);
        chk("reset_result", EX_div_result, 32'd0);
        chk("reset_stall", 32'(div_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 0);
        run_op("modu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34, 0);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op("mod_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("mod_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);
        run_op("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
        run_op("mod_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 0);
        run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0);
        run_op("divu_by0", 2'b01, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 2, 0);
        run_op("mod_m5_by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2, 0);
        run_op("divu_stall", 2'b01, 32'd100, 32'd7, 32'd14, 34, 3);

        // Flush in cycle 10 of a divide.
        @(negedge clk);
        EX_div_en   = 1'b1;
        EX_div_op   = 2'b01;
        EX_div_src1 = 32'd1000;
        EX_div_src2 = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'(div_stall), 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        EX_div_en = 1'b0;
        chk("flush_c11_stall", 32'(div_stall), 32'd0);
        chk("flush_c11_done", 32'(EX_div_done), 32'd0);
        watch_quiet("flush_no_done", 40);
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34, 0);

        // Flush together with a new request in IDLE.
        @(negedge clk);
        EX_div_en   = 1'b1;
        flush       = 1'b1;
        EX_div_op   = 2'b01;
        EX_div_src1 = 32'd50;
        EX_div_src2 = 32'd5;
        @(posedge clk);
        #1;
        EX_div_en = 1'b0;
        flush     = 1'b0;
        watch_quiet("flush_en_no_start", 40);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        EX_div_en   = 1'b1;
        EX_div_op   = 2'b01;
        EX_div_src1 = 32'd100;
        EX_div_src2 = 32'd7;
        repeat (15) @(negedge clk);
        rst       = 1'b1;
        EX_div_en = 1'b0;
        #1;
        chk("arst_result", EX_div_result, 32'd0);
        chk("arst_done", 32'(EX_div_done), 32'd0);
        chk("arst_stall", 32'(div_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("modu_post_rst", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 34, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fu_div.md
# fu_div

Iterative 32-bit integer divider sitting alongside the dual ALU in the EX stage. It takes the operands of a divide/modulo instruction in EX and holds the pipeline through a global stall request until the result is ready. It then presents the quotient or remainder to the EX result mux, which feeds the MEM pipeline register. It uses a radix-2 restoring algorithm with signed correction and an explicit divide-by-zero path.

## Interface
Parameters:
- `XLEN`, 32 — operand/result width; only 32 is supported.
- `ITER`, 32 — number of iterations; must equal `XLEN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1 — pipeline clock.
- `rst` input 1 — asynchronous, active-high reset.
- `stall` input 1 — stall request from other units (memory, etc.); freezes only the DONE state.
- `flush` input 1 — EX-stage branch correction; kills any divide in progress.
- `EX_div_en` input 1 — the instruction in EX is a divide/modulo; held high while the pipeline is stalled.
- `EX_div_op` input 2 — `00` DIV (signed quotient), `01` DIVU, `10` MOD (signed remainder), `11` MODU.
- `EX_div_src1` input 32 — dividend.
- `EX_div_src2` input 32 — divisor.
- `div_stall` output 1 — combinational stall request to the pipeline.
- `EX_div_done` output 1 — `EX_div_result` is valid this cycle.
- `EX_div_result` output 32 — selected quotient or remainder.

## Operation
- States: IDLE, PREP, CALC, DONE.
- IDLE:
  - `EX_div_en & ~flush` → PREP.
  - Latch `src1`, `src2`, `op`.
- PREP:
  - For signed ops, take magnitudes and record `q_neg = s1[31]^s2[31]` and `r_neg = s1[31]`.
  - Clear the 64-bit partial remainder `{32'b0,|src1|}` and the 6-bit counter.
  - If `src2 == 0` → DONE directly with quotient `32'hFFFF_FFFF` and remainder `src1` (raw, unsigned form).
  - Otherwise → CALC.
- CALC:
  - One restoring step per cycle: shift left 1, trial-subtract the divisor from the upper 32 bits.
  - If the result is non-negative, keep it and set quotient bit 1.
  - After 32 steps → DONE.
- DONE:
  - Apply sign correction: negate the quotient if `q_neg`, negate the remainder if `r_neg`; signed ops only.
  - Drive `EX_div_result` per `op` and `EX_div_done=1`.
  - Stay in DONE while `stall`; otherwise → IDLE.
- Overflow: `0x8000_0000 / 0xFFFF_FFFF` (signed) falls out naturally as quotient `0x8000_0000`, remainder 0; no special case.
- `div_stall = EX_div_en & (state != DONE) & ~flush`.
- `flush` in any state:
  - Next state IDLE; `EX_div_done` is 0 the next cycle.
  - Partial results are discarded; no restart until a new `EX_div_en` arrives in IDLE.
- Reset: state IDLE, all datapath registers 0, `EX_div_done=0`, `EX_div_result=0`, `div_stall=0` (when `EX_div_en=0`).

## Timing
- Cycle 0: IDLE sees `EX_div_en`; `div_stall=1`.
- Cycle 1: PREP.
- Cycles 2–33: CALC.
- Cycle 34: DONE, result valid, `div_stall=0`; the pipeline advances at the end of the cycle. Total latency is 34 cycles.
- Divide-by-zero: DONE at cycle 2.
- DONE → IDLE is unconditional when `~stall`; `EX_div_en` still high in the DONE cycle does not restart the unit.
- Back-to-back divides: the second instruction enters EX the cycle after DONE and starts from IDLE; there are no bubbles beyond the inherent latency.
- `EX_div_result` is registered and holds its value until the next DONE.
- Simultaneous `flush` and `EX_div_en` in IDLE: no start.

## Structure
- Shared package `div_pkg`:
  - `div_op_e` (DIV, DIVU, MOD, MODU encodings).
  - `div_state_e` (IDLE, PREP, CALC, DONE).
  - Constant `DIV_BY_ZERO_Q = 32'hFFFF_FFFF`.
- Sub-module `div_step`: a combinational single restoring iteration (in: 64-bit remainder, divisor; out: next remainder, quotient bit), instantiated once.
- The top module holds the FSM, counter, sign flags and output register.

## Test plan
- DIVU `100 / 7` → `EX_div_done` at cycle 34, result `14`; MODU with the same operands → `2`. `div_stall` is high in cycles 0–33 and low in cycle 34.
- DIV `-7 / 2` → `0xFFFF_FFFD` (-3); MOD with the same operands → `0xFFFF_FFFF` (-1); MOD `7 / -2` → `1`.
- DIV `0x8000_0000 / 0xFFFF_FFFF` → `0x8000_0000`; MOD with the same operands → `0`.
- DIVU `0x1234 / 0` → `0xFFFF_FFFF` at cycle 2; MOD `-5 / 0` → `0xFFFF_FFFB`.
- `flush` asserted at cycle 10 of a divide → state IDLE at cycle 11, `div_stall=0`, no `EX_div_done`; a following DIVU `9/3` → `3` at 34 cycles after its start.
- External `stall` held 3 cycles during DONE → result held and `EX_div_done=1` for 4 cycles, no restart. `rst` pulsed mid-CALC → all outputs 0 immediately (asynchronous).
